// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack channel among N requesters,
// with an optional grant lock and a stalled-channel watchdog.
module rr_lock_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned PTR_W   = $clog2(N),
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] ack_in,
    output logic         req_out,
    input  logic         ack_out,
    input  logic         lock,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ACKED = 3'd2,
        S_REL   = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    localparam logic [TW-1:0] WDOG_MAX = {TW{1'b1}};

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic             req_out_q, req_out_d;
    logic [N-1:0]     ack_in_q, ack_in_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [TW-1:0]    wdog_q, wdog_d;

    logic             win_found_c;
    logic [PTR_W-1:0] win_idx_c;
    logic             owner_req_c;

    // Round-robin search: first requester at or after the pointer, wrapping at N-1.
    always_comb begin
        int unsigned idx;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!win_found_c && req_in[PTR_W'(idx)]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'(idx);
            end
        end
    end

    assign owner_req_c = req_in[owner_q];

    // Next-state, output and watchdog logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        req_out_d = req_out_q;
        ack_in_d  = ack_in_q;
        grant_d   = grant_q;
        err_d     = err_q;
        wdog_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (win_found_c) begin
                    owner_d   = win_idx_c;
                    grant_d   = N'(1) << win_idx_c;
                    req_out_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // Owner withdrawing its request before the ack is a protocol violation.
                if (!owner_req_c) begin
                    err_d = 1'b1;
                end
                if (ack_out) begin
                    ack_in_d = N'(1) << owner_q;
                    state_d  = S_ACKED;
                end
            end
            S_ACKED: begin
                if (!owner_req_c) begin
                    req_out_d = 1'b0;
                    state_d   = S_REL;
                end
            end
            S_REL: begin
                if (!ack_out) begin
                    ack_in_d = '0;
                    ptr_d    = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + PTR_W'(1);
                    if (lock) begin
                        state_d = S_HOLD;
                    end else begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // Owner keeps priority over a simultaneous lock release.
                if (owner_req_c) begin
                    req_out_d = 1'b1;
                    state_d   = S_REQ;
                end else if (!lock) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                req_out_d = 1'b0;
                ack_in_d  = '0;
                grant_d   = '0;
            end
        endcase

        // Watchdog counts consecutive cycles waiting on the channel, saturating.
        if (state_d == state_q && (state_q == S_REQ || state_q == S_REL)) begin
            wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + TW'(1);
        end
        if (TIMEOUT != 0 && wdog_d == TW'(TIMEOUT)) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            req_out_q <= 1'b0;
            ack_in_q  <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            req_out_q <= req_out_d;
            ack_in_q  <= ack_in_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wdog_q    <= wdog_d;
        end
    end

    assign req_out = req_out_q;
    assign ack_in  = ack_in_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: cycle vector table plus a fairness sequence.
module tb_rr_lock_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_in;
    logic [N-1:0] ack_in;
    logic         req_out;
    logic         ack_out;
    logic         lock;
    logic [N-1:0] grant;
    logic         busy;
    logic         err;

    int checks;
    int failures;

    typedef struct packed {
        logic       ro;
        logic [3:0] ai;
        logic [3:0] g;
        logic       b;
        logic       e;
    } exp_t;

    typedef struct packed {
        logic       r;
        logic [3:0] req;
        logic       ack;
        logic       lck;
        exp_t       exp;
    } vec_t;

    vec_t       vecs[$];
    exp_t       exp_q[$];
    logic [3:0] fair_q[$];

    rr_lock_arbiter #(
        .N      (N),
        .TIMEOUT(4),
        .TW     (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .ack_in (ack_in),
        .req_out(req_out),
        .ack_out(ack_out),
        .lock   (lock),
        .grant  (grant),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic a, input logic l,
                       input logic ro, input logic [3:0] ai, input logic [3:0] g,
                       input logic b, input logic e);
        vec_t v;
        v.r   = r;
        v.req = rq;
        v.ack = a;
        v.lck = l;
        v.exp = '{ro: ro, ai: ai, g: g, b: b, e: e};
        vecs.push_back(v);
    endtask

    initial begin
        exp_t act;
        exp_t exp;
        logic prev_ro;
        int   cyc;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req_in   = '0;
        ack_out  = 1'b0;
        lock     = 1'b0;

        //  r  req     ack lck  ro  ack_in  grant  b  e
        // reset
        add(1, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // single transaction, requester 1
        add(0, 4'b0010, 0, 0,  1, 4'b0000, 4'b0010, 1, 0);
        add(0, 4'b0010, 0, 0,  1, 4'b0000, 4'b0010, 1, 0);
        add(0, 4'b0010, 1, 0,  1, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0010, 1, 0,  1, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 1, 0,  0, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 1, 0,  0, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // requester 2, pointer moves to 3
        add(0, 4'b0100, 0, 0,  1, 4'b0000, 4'b0100, 1, 0);
        add(0, 4'b0100, 1, 0,  1, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b0000, 1, 0,  0, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // wrap: 1001 from pointer 3 serves 3 then 0
        add(0, 4'b1001, 0, 0,  1, 4'b0000, 4'b1000, 1, 0);
        add(0, 4'b1001, 1, 0,  1, 4'b1000, 4'b1000, 1, 0);
        add(0, 4'b0001, 1, 0,  0, 4'b1000, 4'b1000, 1, 0);
        add(0, 4'b0001, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 1, 0);
        // lock during requester 0 REL with 0110 pending
        add(0, 4'b0111, 1, 0,  1, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0110, 1, 0,  0, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0110, 1, 1,  0, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0110, 0, 1,  0, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0110, 0, 1,  0, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0111, 0, 1,  1, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0111, 1, 0,  1, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0110, 1, 0,  0, 4'b0001, 4'b0001, 1, 0);
        add(0, 4'b0110, 0, 1,  0, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0110, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0110, 0, 0,  1, 4'b0000, 4'b0010, 1, 0);
        add(0, 4'b0110, 1, 0,  1, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0100, 1, 0,  0, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0100, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // HOLD: lock drop together with owner re-request, owner wins
        add(0, 4'b0100, 0, 0,  1, 4'b0000, 4'b0100, 1, 0);
        add(0, 4'b0100, 1, 0,  1, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b0000, 1, 1,  0, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b1010, 0, 1,  0, 4'b0000, 4'b0100, 1, 0);
        add(0, 4'b1110, 0, 0,  1, 4'b0000, 4'b0100, 1, 0);
        add(0, 4'b1110, 1, 0,  1, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b1010, 1, 0,  0, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b1010, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1010, 0, 0,  1, 4'b0000, 4'b1000, 1, 0);
        add(0, 4'b1010, 1, 0,  1, 4'b1000, 4'b1000, 1, 0);
        add(0, 4'b0010, 1, 0,  0, 4'b1000, 4'b1000, 1, 0);
        add(0, 4'b0010, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0010, 0, 0,  1, 4'b0000, 4'b0010, 1, 0);
        add(0, 4'b0010, 1, 0,  1, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 1, 0,  0, 4'b0010, 4'b0010, 1, 0);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // watchdog: 4 cycles waiting in REQ, err sticky afterwards
        add(0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 1, 0);
        add(0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 1, 1);
        add(0, 4'b0001, 1, 0,  1, 4'b0001, 4'b0001, 1, 1);
        add(0, 4'b0000, 1, 0,  0, 4'b0001, 4'b0001, 1, 1);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 1);
        add(1, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // owner drops request in REQ
        add(0, 4'b1000, 0, 0,  1, 4'b0000, 4'b1000, 1, 0);
        add(0, 4'b0000, 0, 0,  1, 4'b0000, 4'b1000, 1, 1);
        add(0, 4'b0000, 1, 0,  1, 4'b1000, 4'b1000, 1, 1);
        add(0, 4'b0000, 1, 0,  0, 4'b1000, 4'b1000, 1, 1);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 1);
        add(1, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        // reset in ACKED, then a fresh request
        add(0, 4'b0010, 0, 0,  1, 4'b0000, 4'b0010, 1, 0);
        add(0, 4'b0010, 1, 0,  1, 4'b0010, 4'b0010, 1, 0);
        add(1, 4'b0010, 1, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0100, 0, 0,  1, 4'b0000, 4'b0100, 1, 0);
        add(0, 4'b0100, 1, 0,  1, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b0000, 1, 0,  0, 4'b0100, 4'b0100, 1, 0);
        add(0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000, 0, 0);

        // Apply each vector, queue its expectation, compare after the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].r;
            req_in  = vecs[i].req;
            ack_out = vecs[i].ack;
            lock    = vecs[i].lck;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            act = '{ro: req_out, ai: ack_in, g: grant, b: busy, e: err};
            exp = exp_q.pop_front();
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL vec%0d: got ro=%b ack_in=%b grant=%b busy=%b err=%b, want ro=%b ack_in=%b grant=%b busy=%b err=%b",
                         i, act.ro, act.ai, act.g, act.b, act.e,
                         exp.ro, exp.ai, exp.g, exp.b, exp.e);
            end
        end

        // Fairness: all requesters re-request as soon as their ack drops.
        rst     = 1'b1;
        req_in  = '0;
        ack_out = 1'b0;
        lock    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fair_q.push_back(4'b0001);
        fair_q.push_back(4'b0010);
        fair_q.push_back(4'b0100);
        fair_q.push_back(4'b1000);
        fair_q.push_back(4'b0001);
        prev_ro = 1'b0;
        cyc     = 0;
        while (fair_q.size() > 0 && cyc < 200) begin
            ack_out = req_out;
            req_in  = ~ack_in;
            @(posedge clk);
            #1;
            cyc++;
            if (req_out && !prev_ro) begin
                logic [3:0] want;
                want = fair_q.pop_front();
                checks++;
                if (grant !== want) begin
                    failures++;
                    $display("FAIL fair_grant: got grant=%b, want %b", grant, want);
                end
            end
            prev_ro = req_out;
        end
        checks++;
        if (fair_q.size() != 0) begin
            failures++;
            $display("FAIL fair_timeout: %0d grants outstanding after %0d cycles, want 0",
                     fair_q.size(), cyc);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL fair_err: got err=%b, want 0", err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
